// File: rtl/mp64_led_status.sv
// Debug LED/status unit: heartbeat, per-channel activity stretchers, sticky error flag and
// STATUS/MANUAL/SCAN/LEGACY display modes. Define LED_PWM_EN to add a 4-bit brightness PWM gate.

module mp64_led_status #(
  parameter int CLOCK_HZ     = 100_000_000,
  parameter int HEARTBEAT_HZ = 1,
  parameter int LED_W        = 8,
  parameter int NUM_CH       = 4,
  parameter int STRETCH_MS   = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] act_pulse,
  input  logic              err_pulse,
  input  logic              err_clr,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_mode,
  input  logic [LED_W-1:0]  cfg_pattern,
  input  logic [3:0]        cfg_bright,
  output logic [LED_W-1:0]  led_out,
  output logic              heartbeat,
  output logic              err_sticky
);

  localparam int HB_RAW = CLOCK_HZ / (2 * HEARTBEAT_HZ);
  localparam int HB_DIV = (HB_RAW < 1) ? 1 : HB_RAW;
  localparam int HB_W   = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  localparam logic [HB_W-1:0] HB_MAX = HB_W'(HB_DIV - 1);

  localparam int STRETCH_CYC = (CLOCK_HZ / 1000) * STRETCH_MS;
  localparam int ST_W        = (STRETCH_CYC > 0) ? $clog2(STRETCH_CYC + 1) : 1;
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYC);
  // Channels that would land beyond the top LED bit are simply not displayed.
  localparam int NUM_ACT = (NUM_CH < LED_W - 2) ? NUM_CH : LED_W - 2;

  localparam int POS_W = $clog2(LED_W);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 1);
  localparam logic [7:0] LEGACY_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    MODE_STATUS = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_LEGACY = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic             hb_q, hb_d;
  logic             hb_tick;
  logic             err_q, err_d;
  logic [ST_W-1:0]  stretch_q [NUM_CH];
  logic [ST_W-1:0]  stretch_d [NUM_CH];
  mode_e            mode_q, mode_d;
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic [POS_W-1:0] pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [LED_W-1:0] composed;
  logic             pwm_on;

  always_comb begin
    hb_tick  = (hb_cnt_q == HB_MAX);
    hb_cnt_d = hb_tick ? '0 : hb_cnt_q + 1'b1;
    hb_d     = hb_q ^ hb_tick;
    err_d    = err_pulse | (err_q & ~err_clr);

    for (int i = 0; i < NUM_CH; i++) begin
      if (act_pulse[i]) begin
        stretch_d[i] = ST_LOAD;
      end else if (stretch_q[i] != '0) begin
        stretch_d[i] = stretch_q[i] - 1'b1;
      end else begin
        stretch_d[i] = stretch_q[i];
      end
    end

    // Scan bounces between the end LEDs; each position, ends included, lasts one tick.
    mode_d    = mode_q;
    pattern_d = pattern_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    if (hb_tick) begin
      if (dir_q == DIR_UP) begin
        if (pos_q == POS_MAX) begin
          dir_d = DIR_DOWN;
          pos_d = pos_q - 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          dir_d = DIR_UP;
          pos_d = pos_q + 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
    if (cfg_we) begin
      mode_d    = mode_e'(cfg_mode);
      pattern_d = cfg_pattern;
      pos_d     = '0;
      dir_d     = DIR_UP;
    end

    composed = '0;
    case (mode_q)
      MODE_STATUS: begin
        composed[0] = hb_q;
        composed[1] = err_q;
        for (int i = 0; i < NUM_ACT; i++) begin
          composed[2+i] = (stretch_q[i] != '0);
        end
      end
      MODE_MANUAL: composed = pattern_q;
      MODE_SCAN:   composed = LED_W'(1) << pos_q;
      default: begin
        for (int i = 0; i < LED_W; i++) begin
          composed[i] = LEGACY_BYTE[i[2:0]];
        end
      end
    endcase

    led_d = composed & {LED_W{pwm_on}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_cnt_q  <= '0;
      hb_q      <= 1'b0;
      err_q     <= 1'b0;
      mode_q    <= MODE_STATUS;
      pattern_q <= '0;
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      led_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        stretch_q[i] <= '0;
      end
    end else begin
      hb_cnt_q  <= hb_cnt_d;
      hb_q      <= hb_d;
      err_q     <= err_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      led_q     <= led_d;
      for (int i = 0; i < NUM_CH; i++) begin
        stretch_q[i] <= stretch_d[i];
      end
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_q, pwm_d;
  logic [3:0] bright_q, bright_d;

  // Gate shares the led register stage, so dimming adds no latency.
  always_comb begin
    pwm_d    = pwm_q + 4'd1;
    bright_d = cfg_we ? cfg_bright : bright_q;
    pwm_on   = (pwm_q <= bright_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q    <= 4'd0;
      bright_q <= 4'hF;
    end else begin
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
    end
  end
`else
  logic unused_bright;
  assign unused_bright = ^cfg_bright;
  assign pwm_on        = 1'b1;
`endif

  assign led_out    = led_q;
  assign heartbeat  = hb_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_mp64_led_status.sv
// Self-checking bench for mp64_led_status: edge-indexed behavioural model compared every cycle,
// plus directed literal checks of heartbeat, stretch, error, scan/legacy/manual, PWM and reset.

module tb_mp64_led_status;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] act_pulse;
  logic       err_pulse;
  logic       err_clr;
  logic       cfg_we;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_bright;
  logic [7:0] led_out;
  logic       heartbeat;
  logic       err_sticky;

  int testsRun    = 0;
  int testsFailed = 0;

  mp64_led_status #(
    .CLOCK_HZ    (1000),
    .HEARTBEAT_HZ(50),
    .LED_W       (8),
    .NUM_CH      (4),
    .STRETCH_MS  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .act_pulse  (act_pulse),
    .err_pulse  (err_pulse),
    .err_clr    (err_clr),
    .cfg_we     (cfg_we),
    .cfg_mode   (cfg_mode),
    .cfg_pattern(cfg_pattern),
    .cfg_bright (cfg_bright),
    .led_out    (led_out),
    .heartbeat  (heartbeat),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // Model state, expressed in edges since the last reset: mK counts released edges,
  // mLast holds the edge of each channel's latest pulse, mWrite the edge of the latest config write.
  int         mK;
  int         mLast [4];
  bit         mErr;
  int         mMode;
  logic [7:0] mPat;
  logic [3:0] mBright;
  int         mWrite;
  bit         modelValid = 1'b0;

  function automatic logic [7:0] modelLed();
    logic [7:0] v;
    int n, m, pos;
    v = 8'h00;
    case (mMode)
      0: begin
        v[0] = ((mK / 10) % 2) == 1;
        v[1] = mErr;
        for (int i = 0; i < 4; i++) v[2+i] = (mK - mLast[i]) <= 4;
      end
      1: v = mPat;
      2: begin
        n   = mK / 10 - mWrite / 10;
        m   = n % 14;
        pos = (m <= 7) ? m : 14 - m;
        v   = 8'h01 << pos;
      end
      default: v = 8'hA5;
    endcase
`ifdef LED_PWM_EN
    if (!((mK % 16) <= int'(mBright))) v = 8'h00;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, got, want, $time);
    end
  endtask

  // Inputs change only at negedge, so they are still the sampled values 1 time unit after posedge.
  always @(posedge clk) begin
    logic [7:0] expLed;
    #1;
    expLed = 8'h00;
    if (!rst_n) begin
      mK = 0;
      for (int i = 0; i < 4; i++) mLast[i] = -100;
      mErr       = 1'b0;
      mMode      = 0;
      mPat       = 8'h00;
      mBright    = 4'hF;
      mWrite     = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      expLed = modelLed();
      mK++;
      for (int i = 0; i < 4; i++) if (act_pulse[i]) mLast[i] = mK;
      mErr = err_pulse | (mErr & ~err_clr);
      if (cfg_we) begin
        mMode   = int'(cfg_mode);
        mPat    = cfg_pattern;
        mBright = cfg_bright;
        mWrite  = mK;
      end
    end
    if (modelValid) begin
      checkOutput("model led_out", led_out, expLed);
      checkOutput("model heartbeat", {7'b0, heartbeat}, ((mK / 10) % 2) == 1 ? 8'h01 : 8'h00);
      checkOutput("model err_sticky", {7'b0, err_sticky}, {7'b0, mErr});
    end
  end

  task automatic applyStimulus(input logic rstN, input logic [3:0] act, input logic errP,
                               input logic errC, input logic we, input logic [1:0] mode,
                               input logic [7:0] pat, input logic [3:0] br);
    rst_n       = rstN;
    act_pulse   = act;
    err_pulse   = errP;
    err_clr     = errC;
    cfg_we      = we;
    cfg_mode    = mode;
    cfg_pattern = pat;
    cfg_bright  = br;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
  endtask

  task automatic cfgWrite(input logic [1:0] mode, input logic [7:0] pat, input logic [3:0] br);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, mode, pat, br);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] scanTable [16];
    logic [7:0] seq [16];
    int         hold [16];
    int         idx;
    scanTable = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    repeat (3) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    checkOutput("reset led_out", led_out, 8'h00);
    checkOutput("reset heartbeat", {7'b0, heartbeat}, 8'h00);
    checkOutput("reset err_sticky", {7'b0, err_sticky}, 8'h00);

    // Heartbeat toggles on the 10th released edge; led_out[0] follows one edge later.
    for (int j = 1; j <= 11; j++) begin
      idleCycle();
      if (j == 9)  checkOutput("hb before toggle", {7'b0, heartbeat}, 8'h00);
      if (j == 10) begin
        checkOutput("hb toggled", {7'b0, heartbeat}, 8'h01);
        checkOutput("led0 lags hb", {7'b0, led_out[0]}, 8'h00);
      end
      if (j == 11) checkOutput("led0 follows hb", {7'b0, led_out[0]}, 8'h01);
    end

    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    for (int j = 1; j <= 6; j++) begin
      idleCycle();
      checkOutput($sformatf("single stretch N+%0d", j), {7'b0, led_out[2]}, (j <= 5) ? 8'h01 : 8'h00);
    end

    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(1'b1, (j == 3) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
      if (j == 8 || j == 9)
        checkOutput($sformatf("retrigger N+%0d", j), {7'b0, led_out[2]}, (j <= 8) ? 8'h01 : 8'h00);
    end

    applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 4'hF);
    checkOutput("err set wins", {7'b0, err_sticky}, 8'h01);
    idleCycle();
    checkOutput("led1 err", {7'b0, led_out[1]}, 8'h01);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'hF);
    checkOutput("err cleared", {7'b0, err_sticky}, 8'h00);
    idleCycle();
    checkOutput("led1 cleared", {7'b0, led_out[1]}, 8'h00);

    cfgWrite(2'd2, 8'h00, 4'hF);
    idleCycle();
    idx     = 0;
    seq[0]  = led_out;
    hold[0] = 1;
    for (int i = 1; i < 16; i++) begin
      seq[i]  = 8'h00;
      hold[i] = 0;
    end
    for (int c = 0; c < 170 && idx < 15; c++) begin
      idleCycle();
      if (led_out != seq[idx]) begin
        idx++;
        seq[idx]  = led_out;
        hold[idx] = 1;
      end else begin
        hold[idx]++;
      end
    end
    for (int i = 0; i < 16; i++) checkOutput($sformatf("scan step %0d", i), seq[i], scanTable[i]);
    for (int i = 1; i < 15; i++) checkOutput($sformatf("scan hold %0d", i), 8'(hold[i]), 8'd10);

    cfgWrite(2'd3, 8'h00, 4'hF);
    idleCycle();
    checkOutput("legacy pattern", led_out, 8'hA5);
    cfgWrite(2'd1, 8'h3C, 4'hF);
    idleCycle();
    checkOutput("manual pattern", led_out, 8'h3C);

`ifdef LED_PWM_EN
    begin
      int onCnt, badCnt;
      cfgWrite(2'd1, 8'hFF, 4'd3);
      idleCycle();
      onCnt  = 0;
      badCnt = 0;
      for (int c = 0; c < 32; c++) begin
        idleCycle();
        if (led_out == 8'hFF) onCnt++;
        else if (led_out != 8'h00) badCnt++;
      end
      checkOutput("pwm bright3 on count", 8'(onCnt), 8'd8);
      checkOutput("pwm bright3 stray", 8'(badCnt), 8'd0);
      cfgWrite(2'd1, 8'hFF, 4'hF);
      idleCycle();
      onCnt = 0;
      for (int c = 0; c < 16; c++) begin
        idleCycle();
        if (led_out == 8'hFF) onCnt++;
      end
      checkOutput("pwm brightF on count", 8'(onCnt), 8'd16);
    end
`endif

    cfgWrite(2'd2, 8'h00, 4'hF);
    repeat (12) idleCycle();
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    checkOutput("midrun reset led", led_out, 8'h00);
    checkOutput("midrun reset hb", {7'b0, heartbeat}, 8'h00);
    checkOutput("midrun reset err", {7'b0, err_sticky}, 8'h00);
    idleCycle();
    checkOutput("post reset led", led_out, 8'h00);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    idleCycle();
    checkOutput("post reset status", led_out, 8'h04);

    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 299) != 0),
                    {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
                    8'($urandom), 4'($urandom_range(0, 15)));
    end
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
